// File: rtl/udp_tx_sched_if.sv
// UDP header plus AXI-stream payload bundle, N lanes packed side by side.
// Lane i of every field lives at slice i.
interface udp_tx_sched_if #(
   parameter int N = 1
);
   logic [N-1:0]    hdr_valid;
   logic [N-1:0]    hdr_ready;
   logic [6*N-1:0]  ip_dscp;
   logic [2*N-1:0]  ip_ecn;
   logic [8*N-1:0]  ip_ttl;
   logic [32*N-1:0] ip_source_ip;
   logic [32*N-1:0] ip_dest_ip;
   logic [16*N-1:0] source_port;
   logic [16*N-1:0] dest_port;
   logic [16*N-1:0] length;
   logic [16*N-1:0] checksum;
   logic [8*N-1:0]  payload_axis_tdata;
   logic [N-1:0]    payload_axis_tvalid;
   logic [N-1:0]    payload_axis_tlast;
   logic [N-1:0]    payload_axis_tuser;
   logic [N-1:0]    payload_axis_tready;

   modport master (
      output hdr_valid,
      output ip_dscp,
      output ip_ecn,
      output ip_ttl,
      output ip_source_ip,
      output ip_dest_ip,
      output source_port,
      output dest_port,
      output length,
      output checksum,
      output payload_axis_tdata,
      output payload_axis_tvalid,
      output payload_axis_tlast,
      output payload_axis_tuser,
      input  hdr_ready,
      input  payload_axis_tready
   );

   modport slave (
      input  hdr_valid,
      input  ip_dscp,
      input  ip_ecn,
      input  ip_ttl,
      input  ip_source_ip,
      input  ip_dest_ip,
      input  source_port,
      input  dest_port,
      input  length,
      input  checksum,
      input  payload_axis_tdata,
      input  payload_axis_tvalid,
      input  payload_axis_tlast,
      input  payload_axis_tuser,
      output hdr_ready,
      output payload_axis_tready
   );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin UDP transmit scheduler: one requester per frame, registered
// header, locked payload pass-through with length policing.
module udp_tx_sched #(
   parameter int S_COUNT    = 4,
   parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   udp_tx_sched_if.slave         s_udp,
   udp_tx_sched_if.master        m_udp,
   output logic                  grant_valid,
   output logic [CL_S_COUNT-1:0] grant_index,
   output logic                  error_short,
   output logic                  error_long
);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD,
      DROP
   } state_t;

   localparam logic [CL_S_COUNT-1:0] LAST_INIT =
      CL_S_COUNT'(S_COUNT - 1);
   localparam logic [CL_S_COUNT:0] WRAP =
      (CL_S_COUNT + 1)'(S_COUNT);

   state_t                state;
   logic [CL_S_COUNT-1:0] last;
   logic [CL_S_COUNT-1:0] pick;
   logic [CL_S_COUNT-1:0] idx;
   logic [CL_S_COUNT:0]   sum;
   logic                  any_req;
   logic                  grant;
   logic [15:0]           count;
   logic [15:0]           exp_len;

   logic        hdr_valid;
   logic [5:0]  dscp;
   logic [1:0]  ecn;
   logic [7:0]  ttl;
   logic [31:0] source_ip;
   logic [31:0] dest_ip;
   logic [15:0] source_port;
   logic [15:0] dest_port;
   logic [15:0] length;
   logic [15:0] checksum;

   logic [5:0]  sel_dscp;
   logic [1:0]  sel_ecn;
   logic [7:0]  sel_ttl;
   logic [31:0] sel_source_ip;
   logic [31:0] sel_dest_ip;
   logic [15:0] sel_source_port;
   logic [15:0] sel_dest_port;
   logic [15:0] sel_length;
   logic [15:0] sel_checksum;

   logic [7:0]  cur_tdata;
   logic        cur_tvalid;
   logic        cur_tlast;
   logic        cur_tuser;
   logic        m_tready;
   logic        hit_end;
   logic        beat;

   // First valid requester strictly after the previous winner, with wrap.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 1; k <= S_COUNT; k++) begin
         sum = {1'b0, last} + (CL_S_COUNT + 1)'(k);
         if (sum >= WRAP) begin
            sum = sum - WRAP;
         end
         idx = sum[CL_S_COUNT-1:0];
         if (!any_req && s_udp.hdr_valid[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   assign grant = rst_n && (state == IDLE) && any_req;

   always_comb begin
      sel_dscp        = '0;
      sel_ecn         = '0;
      sel_ttl         = '0;
      sel_source_ip   = '0;
      sel_dest_ip     = '0;
      sel_source_port = '0;
      sel_dest_port   = '0;
      sel_length      = '0;
      sel_checksum    = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (pick == CL_S_COUNT'(i)) begin
            sel_dscp        = s_udp.ip_dscp[i*6 +: 6];
            sel_ecn         = s_udp.ip_ecn[i*2 +: 2];
            sel_ttl         = s_udp.ip_ttl[i*8 +: 8];
            sel_source_ip   = s_udp.ip_source_ip[i*32 +: 32];
            sel_dest_ip     = s_udp.ip_dest_ip[i*32 +: 32];
            sel_source_port = s_udp.source_port[i*16 +: 16];
            sel_dest_port   = s_udp.dest_port[i*16 +: 16];
            sel_length      = s_udp.length[i*16 +: 16];
            sel_checksum    = s_udp.checksum[i*16 +: 16];
         end
      end
   end

   always_comb begin
      cur_tdata  = '0;
      cur_tvalid = 1'b0;
      cur_tlast  = 1'b0;
      cur_tuser  = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (grant_index == CL_S_COUNT'(i)) begin
            cur_tdata  = s_udp.payload_axis_tdata[i*8 +: 8];
            cur_tvalid = s_udp.payload_axis_tvalid[i];
            cur_tlast  = s_udp.payload_axis_tlast[i];
            cur_tuser  = s_udp.payload_axis_tuser[i];
         end
      end
   end

   assign m_tready = m_udp.payload_axis_tready[0];
   assign hit_end  = (count + 16'd1) == exp_len;
   assign beat     = (state == PAYLOAD) && cur_tvalid && m_tready;

   always_comb begin
      s_udp.hdr_ready           = '0;
      s_udp.payload_axis_tready = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (grant && pick == CL_S_COUNT'(i)) begin
            s_udp.hdr_ready[i] = 1'b1;
         end
         if (grant_index == CL_S_COUNT'(i)) begin
            s_udp.payload_axis_tready[i] =
               (state == PAYLOAD) ? m_tready : (state == DROP);
         end
      end
   end

   // Length mismatch in either direction (hit_end xor tlast) marks the beat bad.
   always_comb begin
      m_udp.payload_axis_tdata  = '0;
      m_udp.payload_axis_tvalid = '0;
      m_udp.payload_axis_tlast  = '0;
      m_udp.payload_axis_tuser  = '0;
      if (state == PAYLOAD) begin
         m_udp.payload_axis_tdata  = cur_tdata;
         m_udp.payload_axis_tvalid = cur_tvalid;
         m_udp.payload_axis_tlast  = hit_end | cur_tlast;
         m_udp.payload_axis_tuser  = cur_tuser | (hit_end ^ cur_tlast);
      end
   end

   assign grant_valid        = (state != IDLE);
   assign m_udp.hdr_valid    = hdr_valid;
   assign m_udp.ip_dscp      = dscp;
   assign m_udp.ip_ecn       = ecn;
   assign m_udp.ip_ttl       = ttl;
   assign m_udp.ip_source_ip = source_ip;
   assign m_udp.ip_dest_ip   = dest_ip;
   assign m_udp.source_port  = source_port;
   assign m_udp.dest_port    = dest_port;
   assign m_udp.length       = length;
   assign m_udp.checksum     = checksum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last        <= LAST_INIT;
         grant_index <= '0;
         count       <= '0;
         exp_len     <= '0;
         hdr_valid   <= 1'b0;
         dscp        <= '0;
         ecn         <= '0;
         ttl         <= '0;
         source_ip   <= '0;
         dest_ip     <= '0;
         source_port <= '0;
         dest_port   <= '0;
         length      <= '0;
         checksum    <= '0;
         error_short <= 1'b0;
         error_long  <= 1'b0;
      end else begin
         error_short <= 1'b0;
         error_long  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  last        <= pick;
                  grant_index <= pick;
                  hdr_valid   <= 1'b1;
                  dscp        <= sel_dscp;
                  ecn         <= sel_ecn;
                  ttl         <= sel_ttl;
                  source_ip   <= sel_source_ip;
                  dest_ip     <= sel_dest_ip;
                  source_port <= sel_source_port;
                  dest_port   <= sel_dest_port;
                  length      <= sel_length;
                  checksum    <= sel_checksum;
                  // Lengths below 9 still carry one payload byte.
                  exp_len     <= (sel_length >= 16'd9) ?
                                 sel_length - 16'd8 : 16'd1;
                  state       <= HDR;
               end
            end
            HDR: begin
               if (m_udp.hdr_ready[0]) begin
                  hdr_valid <= 1'b0;
                  count     <= '0;
                  state     <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (beat) begin
                  count <= count + 16'd1;
                  if (hit_end && !cur_tlast) begin
                     error_long <= 1'b1;
                     state      <= DROP;
                  end else if (hit_end || cur_tlast) begin
                     error_short <= !hit_end;
                     state       <= IDLE;
                  end
               end
            end
            DROP: begin
               if (cur_tvalid && cur_tlast) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: directed frame table, round-robin and reset
// sequences, then 200 random frames against a frame-level reference model.
module tb_udp_tx_sched;
   localparam int S = 4;

   typedef struct {
      logic [5:0]  dscp;
      logic [1:0]  ecn;
      logic [7:0]  ttl;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [15:0] len;
      logic [15:0] csum;
      int          n;
      logic [7:0]  base;
      int          user_at;
   } frame_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   typedef struct {
      int   req;
      int   len;
      int   n;
      int   nout;
      int   shrt;
      int   lng;
      logic ulast;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       grant_valid;
   logic [1:0] grant_index;
   logic       error_short;
   logic       error_long;

   udp_tx_sched_if #(.N(S)) s_if ();
   udp_tx_sched_if #(.N(1)) m_if ();

   udp_tx_sched #(.S_COUNT(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_udp       (s_if),
      .m_udp       (m_if),
      .grant_valid (grant_valid),
      .grant_index (grant_index),
      .error_short (error_short),
      .error_long  (error_long)
   );

   int errors = 0;
   int checks = 0;

   // Requester-side driver state
   frame_t txq[S][$];
   bit     hdr_done[S];
   int     pos[S];
   bit     throttle = 0;

   // Reference model
   bit     mdl_busy;
   int     mdl_cur;
   int     mdl_last;
   int     mdl_p;
   int     mdl_e;
   frame_t mdl_f;
   bit     pend_short;
   bit     pend_long;
   frame_t exp_hdr[$];
   beat_t  exp_beats[$];
   logic [S-1:0] hs_hdr;
   logic [S-1:0] hs_pay;
   bit           hold_prev;
   logic [143:0] prev_bits;

   // Observations
   int   obs_beats;
   int   obs_short;
   int   obs_long;
   int   obs_hdrs;
   logic obs_ulast;
   int   grant_log[$];

   task automatic chk(input string name, input logic [143:0] act,
                      input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [143:0] fbits(frame_t f);
      return {f.dscp, f.ecn, f.ttl, f.sip, f.dip,
              f.sport, f.dport, f.len, f.csum};
   endfunction

   function automatic logic [143:0] mbits();
      return {m_if.ip_dscp, m_if.ip_ecn, m_if.ip_ttl,
              m_if.ip_source_ip, m_if.ip_dest_ip,
              m_if.source_port, m_if.dest_port,
              m_if.length, m_if.checksum};
   endfunction

   function automatic int e_of(int len);
      return (len >= 9) ? len - 8 : 1;
   endfunction

   function automatic int rr_pick(logic [S-1:0] v, int last);
      for (int k = 1; k <= S; k++) begin
         if (v[(last + k) % S]) return (last + k) % S;
      end
      return -1;
   endfunction

   function automatic logic [S-1:0] oh(int i);
      logic [S-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic bit idle();
      bit e;
      e = !mdl_busy && exp_beats.size() == 0 && exp_hdr.size() == 0;
      for (int i = 0; i < S; i++) e = e && txq[i].size() == 0;
      return e;
   endfunction

   task automatic drive();
      frame_t f;
      for (int i = 0; i < S; i++) begin
         if (txq[i].size() > 0) begin
            f = txq[i][0];
            s_if.hdr_valid[i]               = !hdr_done[i];
            s_if.ip_dscp[i*6 +: 6]          = f.dscp;
            s_if.ip_ecn[i*2 +: 2]           = f.ecn;
            s_if.ip_ttl[i*8 +: 8]           = f.ttl;
            s_if.ip_source_ip[i*32 +: 32]   = f.sip;
            s_if.ip_dest_ip[i*32 +: 32]     = f.dip;
            s_if.source_port[i*16 +: 16]    = f.sport;
            s_if.dest_port[i*16 +: 16]      = f.dport;
            s_if.length[i*16 +: 16]         = f.len;
            s_if.checksum[i*16 +: 16]       = f.csum;
            s_if.payload_axis_tvalid[i]     = hdr_done[i] &&
               (!throttle || $urandom_range(0, 3) != 0);
            s_if.payload_axis_tdata[i*8 +: 8] = f.base + 8'(pos[i]);
            s_if.payload_axis_tlast[i]      = (pos[i] == f.n - 1);
            s_if.payload_axis_tuser[i]      = (pos[i] == f.user_at);
         end else begin
            s_if.hdr_valid[i]               = 1'b0;
            s_if.ip_dscp[i*6 +: 6]          = '0;
            s_if.ip_ecn[i*2 +: 2]           = '0;
            s_if.ip_ttl[i*8 +: 8]           = '0;
            s_if.ip_source_ip[i*32 +: 32]   = '0;
            s_if.ip_dest_ip[i*32 +: 32]     = '0;
            s_if.source_port[i*16 +: 16]    = '0;
            s_if.dest_port[i*16 +: 16]      = '0;
            s_if.length[i*16 +: 16]         = '0;
            s_if.checksum[i*16 +: 16]       = '0;
            s_if.payload_axis_tvalid[i]     = 1'b0;
            s_if.payload_axis_tdata[i*8 +: 8] = '0;
            s_if.payload_axis_tlast[i]      = 1'b0;
            s_if.payload_axis_tuser[i]      = 1'b0;
         end
      end
      m_if.hdr_ready           = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      m_if.payload_axis_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   // Called mid-cycle: check outputs and note which handshakes occur next edge.
   task automatic sample();
      logic [S-1:0] hv;
      logic [S-1:0] exp_hr;
      beat_t        b;
      frame_t       f;
      int           k;
      hv     = s_if.hdr_valid;
      exp_hr = '0;
      if (!mdl_busy && hv != 0) exp_hr = oh(rr_pick(hv, mdl_last));
      chk("hdr_ready", 144'(s_if.hdr_ready), 144'(exp_hr));
      chk("grant_valid", 144'(grant_valid), 144'(mdl_busy));
      chk("error_short", 144'(error_short), 144'(pend_short));
      chk("error_long", 144'(error_long), 144'(pend_long));
      if (mdl_busy) begin
         chk("tready_other", 144'(s_if.payload_axis_tready & ~oh(mdl_cur)), 0);
         chk("grant_index", 144'(grant_index), 144'(mdl_cur));
      end else begin
         chk("tready_idle", 144'(s_if.payload_axis_tready), 0);
      end
      if (hold_prev) begin
         chk("hdr_hold_valid", 144'(m_if.hdr_valid), 1);
         chk("hdr_hold_fields", mbits(), prev_bits);
      end
      if (m_if.payload_axis_tvalid[0] && m_if.payload_axis_tready[0]) begin
         chk("beat_expected", 144'(exp_beats.size() != 0), 1);
         if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            chk("beat", 144'({m_if.payload_axis_tdata, m_if.payload_axis_tlast,
                              m_if.payload_axis_tuser}),
                        144'({b.d, b.l, b.u}));
         end
         obs_beats++;
         if (m_if.payload_axis_tlast[0]) obs_ulast = m_if.payload_axis_tuser[0];
      end
      if (m_if.hdr_valid[0] && m_if.hdr_ready[0]) begin
         chk("hdr_expected", 144'(exp_hdr.size() != 0), 1);
         if (exp_hdr.size() != 0) begin
            f = exp_hdr.pop_front();
            chk("hdr_fields", mbits(), fbits(f));
            k = (f.n < e_of(int'(f.len))) ? f.n : e_of(int'(f.len));
            for (int j = 0; j < k; j++) begin
               b.d = f.base + 8'(j);
               b.l = (j == k - 1);
               b.u = (j == f.user_at) ||
                     (j == k - 1 && f.n != e_of(int'(f.len)));
               exp_beats.push_back(b);
            end
         end
         obs_hdrs++;
      end
      hold_prev = m_if.hdr_valid[0] && !m_if.hdr_ready[0];
      prev_bits = mbits();
      obs_short += int'(error_short);
      obs_long  += int'(error_long);
      hs_hdr = s_if.hdr_valid & s_if.hdr_ready;
      hs_pay = s_if.payload_axis_tvalid & s_if.payload_axis_tready;
   endtask

   task automatic update();
      pend_short = 0;
      pend_long  = 0;
      for (int i = 0; i < S; i++) begin
         if (hs_hdr[i] && txq[i].size() > 0) begin
            mdl_busy = 1;
            mdl_cur  = i;
            mdl_last = i;
            mdl_f    = txq[i][0];
            mdl_e    = e_of(int'(mdl_f.len));
            mdl_p    = 0;
            exp_hdr.push_back(mdl_f);
            grant_log.push_back(i);
            hdr_done[i] = 1;
         end else if (hs_pay[i] && hdr_done[i]) begin
            if (mdl_busy && i == mdl_cur) begin
               mdl_p++;
               if (mdl_p == mdl_e && mdl_f.n > mdl_e) pend_long = 1;
               if (mdl_p == mdl_f.n && mdl_f.n < mdl_e) pend_short = 1;
               if (mdl_p == mdl_f.n) mdl_busy = 0;
            end
            pos[i]++;
            if (pos[i] == txq[i][0].n) begin
               void'(txq[i].pop_front());
               hdr_done[i] = 0;
               pos[i]      = 0;
            end
         end
      end
   endtask

   task automatic tick();
      sample();
      @(posedge clk);
      update();
      #1;
      drive();
      @(negedge clk);
   endtask

   task automatic run_idle(input int budget);
      int c;
      c = 0;
      while (!idle() && c < budget) begin
         tick();
         c++;
      end
      chk("run_done", 144'(idle()), 1);
      repeat (2) tick();
   endtask

   task automatic clear_obs();
      obs_beats = 0;
      obs_short = 0;
      obs_long  = 0;
      obs_hdrs  = 0;
      obs_ulast = 1'b0;
      grant_log.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < S; i++) begin
         txq[i].delete();
         hdr_done[i] = 0;
         pos[i]      = 0;
      end
      drive();
      @(posedge clk);
      @(negedge clk);
      chk("rst_outputs",
          144'({m_if.hdr_valid, m_if.payload_axis_tvalid,
                m_if.payload_axis_tlast, m_if.payload_axis_tuser,
                m_if.payload_axis_tdata, s_if.hdr_ready,
                s_if.payload_axis_tready, grant_valid, grant_index,
                error_short, error_long}), 0);
      chk("rst_hdr_regs", mbits(), 0);
      mdl_busy   = 0;
      mdl_cur    = 0;
      mdl_last   = S - 1;
      pend_short = 0;
      pend_long  = 0;
      hold_prev  = 0;
      hs_hdr     = '0;
      hs_pay     = '0;
      exp_hdr.delete();
      exp_beats.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();
      @(negedge clk);
      clear_obs();
   endtask

   function automatic frame_t mk(int req, int len, int n, int base, int ua);
      frame_t f;
      f.dscp    = 6'(req + 5);
      f.ecn     = 2'(req);
      f.ttl     = 8'(64 + req);
      f.sip     = 32'hC0A8_0000 + 32'(req);
      f.dip     = 32'h0A00_0001 + 32'(len);
      f.sport   = 16'(1000 + req);
      f.dport   = 16'(2000 + n);
      f.len     = 16'(len);
      f.csum    = 16'(base * 3);
      f.n       = n;
      f.base    = 8'(base);
      f.user_at = ua;
      return f;
   endfunction

   vec_t vecs[8];
   int   rr_exp[5];
   int   c;
   int   g;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{req: 0, len: 12,  n: 4,  nout: 4,  shrt: 0, lng: 0, ulast: 1'b0};
      vecs[1] = '{req: 1, len: 16,  n: 3,  nout: 3,  shrt: 1, lng: 0, ulast: 1'b1};
      vecs[2] = '{req: 2, len: 10,  n: 5,  nout: 2,  shrt: 0, lng: 1, ulast: 1'b1};
      vecs[3] = '{req: 3, len: 9,   n: 1,  nout: 1,  shrt: 0, lng: 0, ulast: 1'b0};
      vecs[4] = '{req: 0, len: 0,   n: 1,  nout: 1,  shrt: 0, lng: 0, ulast: 1'b0};
      vecs[5] = '{req: 1, len: 5,   n: 3,  nout: 1,  shrt: 0, lng: 1, ulast: 1'b1};
      vecs[6] = '{req: 2, len: 20,  n: 12, nout: 12, shrt: 0, lng: 0, ulast: 1'b0};
      vecs[7] = '{req: 3, len: 300, n: 1,  nout: 1,  shrt: 1, lng: 0, ulast: 1'b1};
      rr_exp  = '{0, 1, 2, 3, 0};

      rst_n = 1'b0;
      for (int i = 0; i < S; i++) begin
         hdr_done[i] = 0;
         pos[i]      = 0;
      end
      drive();
      do_reset();

      for (int r = 0; r < 8; r++) begin
         clear_obs();
         txq[vecs[r].req].push_back(
            mk(vecs[r].req, vecs[r].len, vecs[r].n, r * 16 + 1, -1));
         run_idle(400);
         chk("vec_beats", 144'(obs_beats), 144'(vecs[r].nout));
         chk("vec_short", 144'(obs_short), 144'(vecs[r].shrt));
         chk("vec_long", 144'(obs_long), 144'(vecs[r].lng));
         chk("vec_ulast", 144'(obs_ulast), 144'(vecs[r].ulast));
         chk("vec_grant_index", 144'(grant_index), 144'(vecs[r].req));
      end

      do_reset();
      for (int i = 0; i < S; i++) txq[i].push_back(mk(i, 9, 1, 16 * i, -1));
      txq[0].push_back(mk(0, 9, 1, 200, -1));
      run_idle(400);
      chk("rr_count", 144'(grant_log.size()), 5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
         chk("rr_order", 144'(grant_log[i]), 144'(rr_exp[i]));
      end

      txq[0].push_back(mk(0, 40, 32, 100, -1));
      c = 0;
      while (obs_beats < 3 && c < 500) begin
         tick();
         c++;
      end
      chk("midframe_reached", 144'(obs_beats >= 3), 1);
      do_reset();
      txq[0].push_back(mk(0, 12, 4, 33, -1));
      run_idle(400);
      chk("post_rst_beats", 144'(obs_beats), 4);
      chk("post_rst_grant", 144'(grant_log.size() == 1 && grant_log[0] == 0), 1);

      do_reset();
      throttle = 1;
      for (int f = 0; f < 200; f++) begin
         frame_t fr;
         int     len;
         int     n;
         g   = $urandom_range(0, S - 1);
         len = $urandom_range(0, 30);
         n   = e_of(len) + $urandom_range(0, 4) - 2;
         if (n < 1) n = 1;
         fr       = mk(g, len, n, $urandom_range(0, 255), -1);
         fr.sip   = $urandom;
         fr.dip   = $urandom;
         fr.csum  = 16'($urandom);
         fr.dscp  = 6'($urandom);
         if ($urandom_range(0, 7) == 0) fr.user_at = $urandom_range(0, n - 1);
         txq[g].push_back(fr);
      end
      run_idle(60000);
      chk("rand_hdr_count", 144'(obs_hdrs), 200);
      throttle = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
